ram_bubble_sorter: RTL and testbench



---
 rtl/ram_bubble_sorter_pkg.sv | 21 ++
 rtl/ram_bubble_sorter.sv | 159 +++++++++++++++
 tb/tb_ram_bubble_sorter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bubble_sorter_pkg.sv
// Shared constants and FSM state encoding for the in-place RAM bubble sorter.
// The state enum is also used by the bench to trace the controller.
package ram_bubble_sorter_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 16;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A,
        S_WAIT_A,
        S_RD_B,
        S_WAIT_B,
        S_CMP,
        S_WR_A,
        S_WR_B,
        S_FIN
    } state_t;

endpackage

// File: rtl/ram_bubble_sorter.sv
// Bus initiator that bubble-sorts the first N words of a single-port RAM in place,
// ascending unsigned, reading each neighbour pair and writing it back only when swapped.
module ram_bubble_sorter
    import ram_bubble_sorter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [15:0]       swap_count,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W:0]   ONE      = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   DEPTH    = ONE << ADDR_W;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W:0]     limit;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                pass_swapped;
    logic [CNT_W-1:0]    lat_cnt;

    logic [ADDR_W:0]     n_eff;
    logic [ADDR_W-1:0]   idx_nx;
    logic                lat_done;
    logic                a_gt_b;
    logic                pass_end;
    logic                finish;
    logic                advance;

    always_comb begin
        n_eff    = (len > DEPTH) ? DEPTH : len;
        idx_nx   = idx + ADDR_W'(1);
        lat_done = (lat_cnt == LAT_LAST);
        a_gt_b   = (a > b);
        pass_end = (({1'b0, idx} + ONE) >= limit);
        // A swap in WR_B always marks the pass as swapped, so only CMP can end early on a clean pass.
        finish   = pass_end && ((limit == ONE) || ((state_q == S_CMP) && !pass_swapped));
        advance  = ((state_q == S_CMP) && !a_gt_b) || (state_q == S_WR_B);
    end

    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (n_eff <= ONE) ? S_FIN : S_RD_A;
            end
            S_RD_A: begin
                mem_rd   = 1'b1;
                mem_addr = idx;
                state_d  = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (lat_done) state_d = S_RD_B;
            end
            S_RD_B: begin
                mem_rd   = 1'b1;
                mem_addr = idx_nx;
                state_d  = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (lat_done) state_d = S_CMP;
            end
            S_CMP: begin
                if (a_gt_b) state_d = S_WR_A;
                else        state_d = finish ? S_FIN : S_RD_A;
            end
            S_WR_A: begin
                mem_wr    = 1'b1;
                mem_addr  = idx;
                mem_wdata = b;
                state_d   = S_WR_B;
            end
            S_WR_B: begin
                mem_wr    = 1'b1;
                mem_addr  = idx_nx;
                mem_wdata = a;
                state_d   = finish ? S_FIN : S_RD_A;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx          <= '0;
            limit        <= '0;
            a            <= '0;
            b            <= '0;
            pass_swapped <= 1'b0;
            lat_cnt      <= '0;
            swap_count   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        swap_count   <= '0;
                        idx          <= '0;
                        limit        <= n_eff - ONE;
                        pass_swapped <= 1'b0;
                    end
                end
                S_RD_A, S_RD_B: lat_cnt <= '0;
                S_WAIT_A: begin
                    if (lat_done) a <= mem_rdata;
                    else          lat_cnt <= lat_cnt + CNT_W'(1);
                end
                S_WAIT_B: begin
                    if (lat_done) b <= mem_rdata;
                    else          lat_cnt <= lat_cnt + CNT_W'(1);
                end
                S_WR_B: begin
                    if (swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
                    pass_swapped <= 1'b1;
                end
                default: ;
            endcase
            // Advance happens in the same cycle as CMP/WR_B; a new pass overrides the swap flag above.
            if (advance) begin
                if (!pass_end) begin
                    idx <= idx_nx;
                end else if (!finish) begin
                    limit        <= limit - ONE;
                    idx          <= '0;
                    pass_swapped <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_bubble_sorter.sv
// Directed bench for ram_bubble_sorter: RAM model, vector table of sorts, and
// hand sequences for write order, re-start while busy and reset during a write.
module tb_ram_bubble_sorter;
    import ram_bubble_sorter_pkg::*;

    localparam int AW = RAM_ADDR_W;
    localparam int DW = RAM_DATA_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic [15:0]   swap_count;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rdata_q = '0;

    always #5 clk = ~clk;

    ram_bubble_sorter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (rdata_q)
    );

    // RAM model: registered read (one cycle latency), write on strobe, bench-side preload.
    logic [DW-1:0]        ram [0:RAM_DEPTH-1];
    logic                 load_img = 1'b0;
    logic                 load_ramp = 1'b0;
    logic [7:0][DW-1:0]   img = '0;
    int                   wr_cnt = 0;
    int                   clash_cnt = 0;
    logic [AW-1:0]        wa_log[$];
    logic [DW-1:0]        wd_log[$];

    always @(posedge clk) begin
        if (load_ramp) begin
            for (int k = 0; k < RAM_DEPTH; k++) ram[k] <= DW'(k);
        end else if (load_img) begin
            for (int k = 0; k < 8; k++) ram[k] <= img[k];
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_rd) rdata_q <= ram[mem_addr];
        if (mem_wr) begin
            wr_cnt <= wr_cnt + 1;
            wa_log.push_back(mem_addr);
            wd_log.push_back(mem_wdata);
        end
        if (mem_rd && mem_wr) clash_cnt <= clash_cnt + 1;
    end

    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0][DW-1:0] w8(input logic [DW-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][DW-1:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    task automatic load(input logic [7:0][DW-1:0] v, input logic ramp);
        img       = v;
        load_ramp = ramp;
        load_img  = !ramp;
        @(posedge clk); #1;
        load_img  = 1'b0;
        load_ramp = 1'b0;
    endtask

    // Start at cycle 0; returns the cycle index of the done pulse and busy-high cycles seen.
    task automatic run(input logic [AW:0] l, input int restart_at,
                       output int done_cyc, output int busy_cyc);
        int cyc;
        done_cyc = -1;
        busy_cyc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 8000) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            start = (cyc == restart_at);
            if (cyc == restart_at) len = 2;
        end
        start = 1'b0;
    endtask

    task automatic check_ram(input string name, input logic [7:0][DW-1:0] exp);
        for (int k = 0; k < 8; k++) exp_q.push_back(exp[k]);
        for (int k = 0; k < 8; k++) check($sformatf("%s_ram%0d", name, k), 32'(ram[k]), 32'(exp_q.pop_front()));
    endtask

    typedef struct packed {
        logic [AW:0]        len;
        logic               ramp;
        logic [7:0][DW-1:0] init;
        logic [7:0][DW-1:0] exp;
        logic [31:0]        swaps;
        logic [31:0]        done_cyc;
        logic [31:0]        restart;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dc, bc, w0, base;
        vec_t v;

        vecs[0] = '{len: 4, ramp: 0, init: w8(1, 2, 3, 4, 0, 0, 0, 0), exp: w8(1, 2, 3, 4, 0, 0, 0, 0),
                    swaps: 0, done_cyc: 16, restart: 0};
        vecs[1] = '{len: 4, ramp: 0, init: w8(4, 3, 2, 1, 0, 0, 0, 0), exp: w8(1, 2, 3, 4, 0, 0, 0, 0),
                    swaps: 6, done_cyc: 43, restart: 0};
        vecs[2] = '{len: 1, ramp: 0, init: w8(9, 1, 7, 3, 0, 0, 0, 0), exp: w8(9, 1, 7, 3, 0, 0, 0, 0),
                    swaps: 0, done_cyc: 1, restart: 0};
        vecs[3] = '{len: 0, ramp: 0, init: w8(5, 4, 3, 2, 1, 0, 0, 0), exp: w8(5, 4, 3, 2, 1, 0, 0, 0),
                    swaps: 0, done_cyc: 1, restart: 0};
        vecs[4] = '{len: 2, ramp: 0, init: w8(7, 3, 1, 0, 0, 0, 0, 0), exp: w8(3, 7, 1, 0, 0, 0, 0, 0),
                    swaps: 1, done_cyc: 8, restart: 0};
        vecs[5] = '{len: 6, ramp: 0, init: w8(16'hFFFF, 0, 5, 5, 16'hFFFF, 1, 2, 0),
                    exp: w8(0, 1, 5, 5, 16'hFFFF, 16'hFFFF, 2, 0), swaps: 7, done_cyc: 90, restart: 0};
        vecs[6] = '{len: 2047, ramp: 1, init: '0, exp: w8(0, 1, 2, 3, 4, 5, 6, 7),
                    swaps: 0, done_cyc: 5116, restart: 0};
        vecs[7] = '{len: 4, ramp: 0, init: w8(4, 3, 2, 1, 0, 0, 0, 0), exp: w8(1, 2, 3, 4, 0, 0, 0, 0),
                    swaps: 6, done_cyc: 43, restart: 10};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_swap_count", 32'(swap_count), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        rst = 1'b0;

        for (int vi = 0; vi < 8; vi++) begin
            v = vecs[vi];
            load(v.init, v.ramp);
            w0 = wr_cnt;
            run(v.len, int'(v.restart), dc, bc);
            check($sformatf("v%0d_done_cycle", vi), 32'(dc), v.done_cyc);
            check($sformatf("v%0d_busy_cycles", vi), 32'(bc), v.done_cyc - 1);
            check($sformatf("v%0d_swap_count", vi), 32'(swap_count), v.swaps);
            check($sformatf("v%0d_writes", vi), 32'(wr_cnt - w0), 2 * v.swaps);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_width", vi), 32'(done), 0);
            check_ram($sformatf("v%0d", vi), v.exp);
        end

        // First swap of a reversed run writes the smaller word low, then the larger one high.
        load(w8(4, 3, 2, 1, 0, 0, 0, 0), 1'b0);
        base = wa_log.size();
        run(4, 0, dc, bc);
        check("order_wr_count", 32'(wa_log.size() >= base + 2), 1);
        if (wa_log.size() >= base + 2) begin
            check("order_wr0_addr", 32'(wa_log[base]), 0);
            check("order_wr0_data", 32'(wd_log[base]), 3);
            check("order_wr1_addr", 32'(wa_log[base + 1]), 1);
            check("order_wr1_data", 32'(wd_log[base + 1]), 4);
        end
        @(posedge clk); #1;

        // Reset during the first WR_A: that write lands, the second does not.
        load(w8(4, 3, 2, 1, 0, 0, 0, 0), 1'b0);
        start = 1'b1;
        len   = 4;
        @(posedge clk); #1;
        start = 1'b0;
        dc = 0;
        while (dut.state_q != S_WR_A && dc < 200) begin
            @(posedge clk); #1;
            dc++;
        end
        check("rstmid_reached_wr_a", 32'(dut.state_q), 32'(S_WR_A));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_done", 32'(done), 0);
        check("rstmid_swap_count", 32'(swap_count), 0);
        check("rstmid_mem_rd", 32'(mem_rd), 0);
        check("rstmid_mem_wr", 32'(mem_wr), 0);
        check("rstmid_mem_addr", 32'(mem_addr), 0);
        check("rstmid_mem_wdata", 32'(mem_wdata), 0);
        check("rstmid_state", 32'(dut.state_q), 32'(S_IDLE));
        check_ram("rstmid", w8(3, 3, 2, 1, 0, 0, 0, 0));
        rst = 1'b0;
        run(4, 0, dc, bc);
        check("resort_done_cycle", 32'(dc), 41);
        check("resort_swap_count", 32'(swap_count), 5);
        check_ram("resort", w8(1, 2, 3, 3, 0, 0, 0, 0));

        check("rd_wr_clash", 32'(clash_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
